// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for the multi-cycle ALU.
// Pure declarations: no logic, no latency, no flow control.
package alu_pkg;

   localparam logic [3:0] OP_MOV = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_CMP = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NEG = 4'd7;
   localparam logic [3:0] OP_NOT = 4'd8;
   localparam logic [3:0] OP_SLL = 4'd9;
   localparam logic [3:0] OP_SRL = 4'd10;
   localparam logic [3:0] OP_SRA = 4'd11;
   localparam logic [3:0] OP_MUL = 4'd12;
   localparam logic [3:0] OP_DIV = 4'd13;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic sf;
      logic zf;
      logic cf;
      logic vf;
   } flags_t;

endpackage

// File: rtl/alu_mc_iter.sv
// Shared shift-add multiply / restoring divide iterator, one bit per cycle (divide only with ALU_MC_DIV_EN).
// Latency WIDTH cycles after start; no backpressure, the top FSM owns sequencing.
module alu_mc_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef ALU_MC_DIV_EN
   input  logic             div_mode,
`endif
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             done,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH:0]   mul_sum;
`ifdef ALU_MC_DIV_EN
   logic             div_q, div_d;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_sub;
   logic             rem_ge;
`endif

   // One iteration step; the top latches hi_nxt/lo_nxt on the final step.
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      hi_nxt  = mul_sum[WIDTH:1];
      lo_nxt  = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
      rem_sh  = {hi_q, lo_q[WIDTH-1]};
      rem_ge  = (rem_sh >= {1'b0, opnd_q});
      rem_sub = rem_sh[WIDTH-1:0] - opnd_q;
      if (div_q) begin
         hi_nxt = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
         lo_nxt = {lo_q[WIDTH-2:0], rem_ge};
      end
`endif
   end

   always_comb begin
      cnt_d  = cnt_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      opnd_d = opnd_q;
`ifdef ALU_MC_DIV_EN
      div_d  = div_q;
`endif
      if (start) begin
         cnt_d  = CNT_W'(WIDTH);
         hi_d   = '0;
         lo_d   = opb;
         opnd_d = opa;
`ifdef ALU_MC_DIV_EN
         div_d  = div_mode;
         if (div_mode) begin
            lo_d   = opa;
            opnd_d = opb;
         end
`endif
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
         hi_d  = hi_nxt;
         lo_d  = lo_nxt;
      end
   end

   assign done = (cnt_q == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         opnd_q <= '0;
`ifdef ALU_MC_DIV_EN
         div_q  <= 1'b0;
`endif
      end else begin
         cnt_q  <= cnt_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         opnd_q <= opnd_d;
`ifdef ALU_MC_DIV_EN
         div_q  <= div_d;
`endif
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Execute-stage ALU: registered single-cycle ops plus iterative MUL/DIV (DIV built only with ALU_MC_DIV_EN).
// Latency 1 (WIDTH+1 for MUL/DIV); result held until out_ready, back-to-back accept on handshake.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SH_W  = $clog2(WIDTH),
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SH_W-1:0]  shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dr,
   output logic [WIDTH-1:0] dr_hi,
   output logic             sf,
   output logic             zf,
   output logic             cf,
   output logic             vf,
   output logic             flag_up,
   output logic             illegal
);

   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dr_q, dr_d, dr_hi_q, dr_hi_d;
   flags_t           flags_q, flags_d;
   logic             flag_up_q, flag_up_d, illegal_q, illegal_d;

   logic             accept, is_multi, busy_div, iter_start, iter_done;
   logic [WIDTH-1:0] iter_hi, iter_lo;
   logic [WIDTH:0]   add_w, sub_w;
   logic [SH_W-1:0]  sll_idx, srl_idx;
   logic [WIDTH-1:0] res_lo, res_hi;
   logic             res_cf, res_vf, res_fu, res_ill;
   flags_t           res_f, iter_f;

`ifdef ALU_MC_DIV_EN
   logic div_q, div_d;
   assign busy_div = div_q;
   assign is_multi = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
`else
   assign busy_div = 1'b0;
   assign is_multi = (op == OP_MUL);
`endif

   assign in_ready  = rst_n && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
   assign out_valid = (state_q == S_DONE);
   assign accept    = in_valid && in_ready;
   assign add_w     = {1'b0, a} + {1'b0, b};
   assign sub_w     = {1'b0, a} - {1'b0, b};
   // W - shamt wraps to -shamt because WIDTH is a power of two.
   assign sll_idx   = '0 - shamt;
   assign srl_idx   = shamt - SH_W'(1);

   always_comb begin
      res_lo  = '0;
      res_hi  = '0;
      res_cf  = 1'b0;
      res_vf  = 1'b0;
      res_fu  = 1'b1;
      res_ill = 1'b0;
      case (op)
         OP_MOV: begin res_lo = b; res_fu = 1'b0; end
         OP_ADD: begin
            res_lo = add_w[WIDTH-1:0];
            res_cf = add_w[WIDTH];
            res_vf = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            res_lo = sub_w[WIDTH-1:0];
            res_cf = sub_w[WIDTH];
            res_vf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: res_lo = a & b;
         OP_OR:  res_lo = a | b;
         OP_XOR: res_lo = a ^ b;
         OP_NEG: begin
            res_lo = '0 - a;
            res_cf = (a != '0);
            res_vf = (a == MIN_INT);
         end
         OP_NOT: begin res_lo = ~a; res_fu = 1'b0; end
         OP_SLL: begin
            res_lo = a << shamt;
            res_cf = (shamt != '0) && a[sll_idx];
         end
         OP_SRL: begin
            res_lo = a >> shamt;
            res_cf = (shamt != '0) && a[srl_idx];
         end
         OP_SRA: begin
            res_lo = WIDTH'($signed(a) >>> shamt);
            res_cf = (shamt != '0) && a[srl_idx];
         end
         OP_MUL: ;
`ifdef ALU_MC_DIV_EN
         OP_DIV: if (b == '0) begin
            res_lo = '1;
            res_hi = a;
            res_vf = 1'b1;
         end
`endif
         default: begin res_fu = 1'b0; res_ill = 1'b1; end
      endcase
      res_f.sf = res_lo[WIDTH-1];
      res_f.zf = (res_lo == '0);
      res_f.cf = res_cf;
      res_f.vf = res_vf;
      if (res_ill) res_f = '0;
      iter_f.sf = iter_lo[WIDTH-1];
      iter_f.zf = (iter_lo == '0);
      iter_f.cf = !busy_div && (iter_hi != '0);
      iter_f.vf = !busy_div && (iter_hi != '0);
   end

   always_comb begin
      state_d    = state_q;
      dr_d       = dr_q;
      dr_hi_d    = dr_hi_q;
      flags_d    = flags_q;
      flag_up_d  = flag_up_q;
      illegal_d  = illegal_q;
      iter_start = 1'b0;
`ifdef ALU_MC_DIV_EN
      div_d      = div_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               if (is_multi) begin
                  state_d    = S_BUSY;
                  iter_start = 1'b1;
`ifdef ALU_MC_DIV_EN
                  div_d      = (op == OP_DIV);
`endif
               end else begin
                  state_d   = S_DONE;
                  dr_d      = res_lo;
                  dr_hi_d   = res_hi;
                  flags_d   = res_f;
                  flag_up_d = res_fu;
                  illegal_d = res_ill;
               end
            end else if ((state_q == S_DONE) && out_ready) begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            if (iter_done) begin
               state_d   = S_DONE;
               dr_d      = iter_lo;
               dr_hi_d   = iter_hi;
               flags_d   = iter_f;
               flag_up_d = 1'b1;
               illegal_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         dr_q      <= '0;
         dr_hi_q   <= '0;
         flags_q   <= '0;
         flag_up_q <= 1'b0;
         illegal_q <= 1'b0;
`ifdef ALU_MC_DIV_EN
         div_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         dr_q      <= dr_d;
         dr_hi_q   <= dr_hi_d;
         flags_q   <= flags_d;
         flag_up_q <= flag_up_d;
         illegal_q <= illegal_d;
`ifdef ALU_MC_DIV_EN
         div_q     <= div_d;
`endif
      end
   end

   alu_mc_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (iter_start),
`ifdef ALU_MC_DIV_EN
      .div_mode (op == OP_DIV),
`endif
      .opa      (a),
      .opb      (b),
      .done     (iter_done),
      .hi_nxt   (iter_hi),
      .lo_nxt   (iter_lo)
   );

   assign dr      = dr_q;
   assign dr_hi   = dr_hi_q;
   assign sf      = flags_q.sf;
   assign zf      = flags_q.zf;
   assign cf      = flags_q.cf;
   assign vf      = flags_q.vf;
   assign flag_up = flag_up_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32): latency, flags, backpressure, reset abort, illegal ops.
module tb_alu_mc;
   localparam int W = 32;

   logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]    op;
   logic [W-1:0]  a, b, dr, dr_hi;
   logic [4:0]    shamt;
   logic          sf, zf, cf, vf, flag_up, illegal;
   int            vec = 0;
   int            errs = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .shamt(shamt), .out_valid(out_valid),
      .out_ready(out_ready), .dr(dr), .dr_hi(dr_hi), .sf(sf), .zf(zf),
      .cf(cf), .vf(vf), .flag_up(flag_up), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [4:0] s);
      op = o; a = x; b = y; shamt = s; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
   endtask

   // Expected flags given as {sf,zf,cf,vf}.
   task automatic check_res(input string tag, input logic [W-1:0] e_dr, input logic [W-1:0] e_hi,
                            input logic [3:0] e_f, input logic e_fu, input logic e_ill);
      chk(tag, {9'b0, out_valid, dr_hi, dr, sf, zf, cf, vf, flag_up, illegal},
               {9'b0, 1'b1, e_hi, e_dr, e_f, e_fu, e_ill});
   endtask

   task automatic take();
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
   endtask

   task automatic run1(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [4:0] s, input logic [W-1:0] e_dr,
                       input logic [W-1:0] e_hi, input logic [3:0] e_f, input logic e_fu,
                       input logic e_ill);
      send(o, x, y, s);
      check_res(tag, e_dr, e_hi, e_f, e_fu, e_ill);
      take();
   endtask

   // Cycles from accept until out_valid; 1 means the cycle right after the accept edge.
   task automatic wait_valid(output int n, output int rdy_seen);
      n = 1;
      rdy_seen = 0;
      while (!out_valid && n < 100) begin
         if (in_ready) rdy_seen++;
         cyc();
         n++;
      end
   endtask

   int n, rdy_seen, bad;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = '0; a = '0; b = '0; shamt = '0;
      repeat (2) cyc();
      chk("reset_state", {9'b0, in_ready, out_valid, dr, dr_hi, sf, zf, cf, vf, flag_up, illegal}, 80'd0);
      rst_n = 1'b1;
      cyc();
      chk("idle_ready", {78'd0, in_ready, out_valid}, {78'd0, 1'b1, 1'b0});

      run1("add_carry", 4'd1, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 32'd0, 4'b0110, 1'b1, 1'b0);
      run1("add_ovf", 4'd1, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 32'd0, 4'b1001, 1'b1, 1'b0);
      run1("sub_borrow", 4'd2, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 32'd0, 4'b1010, 1'b1, 1'b0);
      run1("sra_1", 4'd11, 32'h8000_0001, 32'd0, 5'd1, 32'hC000_0000, 32'd0, 4'b1010, 1'b1, 1'b0);
      run1("sll_0", 4'd9, 32'h1234_5678, 32'd0, 5'd0, 32'h1234_5678, 32'd0, 4'b0000, 1'b1, 1'b0);
      run1("sll_1", 4'd9, 32'h8000_0001, 32'd0, 5'd1, 32'h0000_0002, 32'd0, 4'b0010, 1'b1, 1'b0);
      run1("srl_1", 4'd10, 32'd3, 32'd0, 5'd1, 32'd1, 32'd0, 4'b0010, 1'b1, 1'b0);
      run1("neg_min", 4'd7, 32'h8000_0000, 32'd0, 5'd0, 32'h8000_0000, 32'd0, 4'b1011, 1'b1, 1'b0);
      run1("neg_zero", 4'd7, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 4'b0100, 1'b1, 1'b0);
      run1("cmp_eq", 4'd3, 32'd5, 32'd5, 5'd0, 32'd0, 32'd0, 4'b0100, 1'b1, 1'b0);
      run1("xor", 4'd6, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_0FF0, 32'd0, 4'b0000, 1'b1, 1'b0);
      run1("not", 4'd8, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 4'b1000, 1'b0, 1'b0);
      run1("mov_zero", 4'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 4'b0100, 1'b0, 1'b0);

      // MUL with a competing ADD offered throughout BUSY; it must be ignored.
      send(4'd12, 32'h0001_0000, 32'h0001_0000, 5'd0);
      op = 4'd1; a = 32'd1; b = 32'd1; in_valid = 1'b1;
      wait_valid(n, rdy_seen);
      in_valid = 1'b0;
      chk("mul_latency", 80'(n), 80'd33);
      chk("mul_busy_rdy", 80'(rdy_seen), 80'd0);
      check_res("mul_hi", 32'd0, 32'd1, 4'b0111, 1'b1, 1'b0);
      take();
      send(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
      wait_valid(n, rdy_seen);
      check_res("mul_max", 32'd1, 32'hFFFF_FFFE, 4'b0011, 1'b1, 1'b0);
      take();
      send(4'd12, 32'd3, 32'd5, 5'd0);
      wait_valid(n, rdy_seen);
      check_res("mul_small", 32'd15, 32'd0, 4'b0000, 1'b1, 1'b0);
      take();

`ifdef ALU_MC_DIV_EN
      send(4'd13, 32'd100, 32'd7, 5'd0);
      wait_valid(n, rdy_seen);
      chk("div_latency", 80'(n), 80'd33);
      check_res("div_100_7", 32'd14, 32'd2, 4'b0000, 1'b1, 1'b0);
      take();
      run1("div_by0", 4'd13, 32'd100, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'd100, 4'b1001, 1'b1, 1'b0);
`else
      run1("div_off", 4'd13, 32'd100, 32'd7, 5'd0, 32'd0, 32'd0, 4'b0000, 1'b0, 1'b1);
      run1("div_off_b0", 4'd13, 32'd100, 32'd0, 5'd0, 32'd0, 32'd0, 4'b0000, 1'b0, 1'b1);
`endif

      // Backpressure: result must hold, then handshake and a new accept in one cycle.
      send(4'd1, 32'd1, 32'd2, 5'd0);
      check_res("bp_first", 32'd3, 32'd0, 4'b0000, 1'b1, 1'b0);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (in_ready || !out_valid || dr !== 32'd3 || {sf, zf, cf, vf} !== 4'b0000) bad++;
         cyc();
      end
      chk("bp_stable", 80'(bad), 80'd0);
      op = 4'd1; a = 32'd10; b = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("bp_b2b_ready", {79'd0, in_ready}, 80'd1);
      cyc();
      in_valid = 1'b0; out_ready = 1'b0;
      check_res("bp_b2b_res", 32'd30, 32'd0, 4'b0000, 1'b1, 1'b0);
      take();

      // Reset in cycle 10 of a MUL; dr still shows the earlier 30.
      send(4'd12, 32'd5, 32'd7, 5'd0);
      repeat (9) cyc();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_mul", {9'b0, in_ready, out_valid, dr, dr_hi, sf, zf, cf, vf, flag_up, illegal}, 80'd0);
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("rst_release", {78'd0, in_ready, out_valid}, {78'd0, 1'b1, 1'b0});
      repeat (40) cyc();
      chk("rst_no_stale", {79'd0, out_valid}, 80'd0);

      run1("illegal_15", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 32'd0, 32'd0, 4'b0000, 1'b0, 1'b1);
      run1("illegal_14", 4'd14, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 32'd0, 4'b0000, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
